fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Control and address generator for a runtime-sized radix-2 DIT FFT, in-place addressing over ping-pong banks.
//  Successor to the fixed 1024-point core control: size (2..2^MAX_LOG2N points) chosen per run, adds inverse mode and abort.
//  Drives the butterfly datapath, the two data RAM banks and the twiddle ROM.
//  Input data is preloaded bit-reversed into bank 0.
// PARAMETERS
//  MAX_LOG2N  10  largest transform log2 size; twiddle ROM holds 2^(MAX_LOG2N-1) entries
//  PIPE_LAT   4   butterfly datapath latency, read-issue to write-back, in cycles (>=1)
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            asynchronous active-low reset
//  start        in   1            1-cycle request; sampled only in IDLE
//  log2n        in   4            transform size log2; latched on accepted start
//  inverse      in   1            IFFT request; latched on accepted start
//  abort        in   1            synchronous abort, any state
//  busy         out  1            high from cycle after accepted start until done/abort
//  done         out  1            1-cycle completion pulse
//  err          out  1            valid with done: log2n out of range
//  rd_en        out  1            butterfly read issue
//  rd_addr_a    out  MAX_LOG2N    upper-leg address
//  rd_addr_b    out  MAX_LOG2N    lower-leg address
//  rd_bank      out  1            bank read this stage
//  tw_addr      out  MAX_LOG2N-1  twiddle ROM index, full-size scaled
//  tw_conj      out  1            conjugate twiddle (= latched inverse)
//  scale_half   out  1            datapath halves outputs (= latched inverse)
//  wr_en        out  1            write-back strobe
//  wr_addr_a    out  MAX_LOG2N    rd_addr_a delayed PIPE_LAT
//  wr_addr_b    out  MAX_LOG2N    rd_addr_b delayed PIPE_LAT
//  wr_bank      out  1            ~rd_bank of the issuing stage, delayed with the write
//  result_bank  out  1            bank holding the final result (= L mod 2); valid from done until next start
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, delay line cleared.
//  - FSM: IDLE -start-> ISSUE (valid log2n) or ERR (log2n==0 or >MAX_LOG2N).
//    ISSUE -last j-> DRAIN. DRAIN -PIPE_LAT cycles-> ISSUE(s+1), or DONE if s==L-1. DONE -> IDLE. ERR -> IDLE.
//  - Variables: L = log2n, N = 2^L. Butterfly j runs 0..N/2-1, one per cycle in ISSUE; stage s runs 0..L-1.
//  - Addressing: half = 2^s, grp = j>>s, pos = j&(half-1).
//    a = (grp<<(s+1))|pos, b = a+half, tw = pos<<(MAX_LOG2N-1-s).
//  - Banks: rd_bank = s mod 2; writes go to the other bank.
//  - Timing (start sampled at cycle 0): ISSUE stage s occupies cycles s*P+1 .. s*P+N/2, where P = N/2+PIPE_LAT.
//    wr_en follows each rd_en by exactly PIPE_LAT cycles.
//    Next stage issues one cycle after the last write of the previous stage.
//  - done pulses at cycle L*P+1; busy falls in the same cycle.
//  - ERR path: done=1, err=1 at cycle 1; no rd_en/wr_en; busy stays 0.
//  - start while busy, or in the DONE cycle: ignored, no side effects.
//  - abort: next cycle FSM=IDLE, busy=0, delay line flushed (no further wr_en), no done.
//    abort and start in the same cycle in IDLE: abort wins.
//  - Reset mid-run: identical to abort, asynchronous.
//  - log2n==1: single stage, one butterfly, done at cycle 1+PIPE_LAT+1.
// STRUCTURE
//  - fft_pkg: MAX_LOG2N default, state enum (IDLE, ISSUE, DRAIN, DONE, ERR), addr_t/tw_t typedefs.
//  - Sub-module fft_pipe_delay: PIPE_LAT-deep shift register of {valid, addr_a, addr_b, bank} with flush input.
//  - Top: FSM, j/s counters, drain counter, address arithmetic.
// TESTING (MAX_LOG2N=10, PIPE_LAT=4)
//  - log2n=3, start at cycle 0 -> 12 rd_en total; stage0 j=0: a=0, b=1, tw=0.
//    Stage1 j=3: a=5, b=7, tw=256. Stage2 j=1: a=1, b=5, tw=128. done at cycle 25; result_bank=1.
//  - log2n=10, inverse=1 -> 5120 rd_en and 5120 wr_en. Every wr matches its rd addresses 4 cycles later, bank inverted.
//    tw_conj=scale_half=1 throughout; done at cycle 5161; result_bank=0.
//  - log2n=0, then log2n=11 -> done=err=1 at cycle 1; no rd_en/wr_en; busy never rises.
//  - abort during stage 1 of log2n=4 -> busy=0 next cycle; no wr_en afterwards; no done. A following start runs cleanly.
//  - start pulsed while busy, and rst_n dropped mid-run -> start has no effect.
//    Reset forces all outputs to 0 immediately; the next run is correct.
//  - log2n=1 -> single butterfly a=0, b=1, tw=0; wr at cycle 5; done at cycle 6.

Source files
------------

// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and defaults for the runtime-sized radix-2 DIT FFT sequencer.
package fft_stage_sequencer_pkg;

  // Largest supported transform, log2 points.
  localparam int unsigned MAX_LOG2N_DEF = 10;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone,
    StErr
  } state_e;

  // Bank address and twiddle ROM index for the default maximum size.
  typedef logic [MAX_LOG2N_DEF-1:0] addr_t;
  typedef logic [MAX_LOG2N_DEF-2:0] tw_t;

endpackage

// File: rtl/fft_stage_sequencer_pipe_delay.sv
// Shift register matching the butterfly datapath latency: carries the write
// strobe, both leg addresses and the destination bank from read issue to write-back.
module fft_stage_sequencer_pipe_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  input  logic          i_bank,
  output logic          o_valid,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b,
  output logic          o_bank
);

  localparam int unsigned W = 2 * AW + 2;

  logic [W-1:0] r_pipe [DEPTH];

  // Advance the delay line; flush drops every in-flight write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pipe[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {i_valid, i_addr_a, i_addr_b, i_bank};
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign {o_valid, o_addr_a, o_addr_b, o_bank} = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control and address generator for a runtime-sized in-place radix-2 DIT FFT
// running over two ping-pong data banks. Data is expected bit-reversed in bank 0.
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LOG2N = MAX_LOG2N_DEF,
  parameter int unsigned PIPE_LAT  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [3:0]             i_log2n,
  input  logic                   i_inverse,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_rd_en,
  output logic [MAX_LOG2N-1:0]   o_rd_addr_a,
  output logic [MAX_LOG2N-1:0]   o_rd_addr_b,
  output logic                   o_rd_bank,
  output logic [MAX_LOG2N-2:0]   o_tw_addr,
  output logic                   o_tw_conj,
  output logic                   o_scale_half,
  output logic                   o_wr_en,
  output logic [MAX_LOG2N-1:0]   o_wr_addr_a,
  output logic [MAX_LOG2N-1:0]   o_wr_addr_b,
  output logic                   o_wr_bank,
  output logic                   o_result_bank
);

  localparam int unsigned JW = MAX_LOG2N - 1;
  localparam int unsigned DW = $clog2(PIPE_LAT + 1);

  state_e               r_state;
  logic [3:0]           r_log2n;
  logic                 r_inverse;
  logic [3:0]           r_s;
  logic [JW-1:0]        r_j;
  logic [DW-1:0]        r_drain;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic                 r_result_bank;
  logic                 r_rd_en;
  logic [MAX_LOG2N-1:0] r_rd_addr_a;
  logic [MAX_LOG2N-1:0] r_rd_addr_b;
  logic                 r_rd_bank;
  logic [MAX_LOG2N-2:0] r_tw_addr;

  logic                 w_start_ok;
  logic [JW-1:0]        w_j_last;
  logic                 w_last_j;
  logic                 w_last_s;
  logic                 w_drain_end;
  logic [JW-1:0]        w_calc_j;
  logic [3:0]           w_calc_s;
  logic [MAX_LOG2N-1:0] w_jx;
  logic [MAX_LOG2N-1:0] w_half;
  logic [MAX_LOG2N-1:0] w_pos;
  logic [MAX_LOG2N-1:0] w_grp;
  logic [MAX_LOG2N-1:0] w_a;
  logic [MAX_LOG2N-1:0] w_b;
  logic [MAX_LOG2N-2:0] w_tw;

  // Range check of the requested size and end-of-loop conditions.
  always_comb begin
    w_start_ok  = (i_log2n != 4'd0) && ({28'd0, i_log2n} <= MAX_LOG2N);
    w_j_last    = JW'((32'd1 << (r_log2n - 4'd1)) - 32'd1);
    w_last_j    = (r_j == w_j_last);
    w_last_s    = (r_s == (r_log2n - 4'd1));
    w_drain_end = (r_drain == DW'(PIPE_LAT - 1));
  end

  // Butterfly index to be presented next cycle: j+1 within a stage, (0, s+1)
  // after a drain, (0, 0) on a fresh start.
  always_comb begin
    w_calc_j = '0;
    w_calc_s = '0;
    if (r_state == StIssue) begin
      w_calc_j = r_j + JW'(1);
      w_calc_s = r_s;
    end else if (r_state == StDrain) begin
      w_calc_s = r_s + 4'd1;
    end
  end

  // In-place DIT addressing; b never carries into higher bits since pos < half.
  always_comb begin
    w_jx   = MAX_LOG2N'(w_calc_j);
    w_half = MAX_LOG2N'(1) << w_calc_s;
    w_pos  = w_jx & (w_half - MAX_LOG2N'(1));
    w_grp  = w_jx >> w_calc_s;
    w_a    = (w_grp << (w_calc_s + 4'd1)) | w_pos;
    w_b    = w_a | w_half;
    // Twiddle index scaled to the full-size ROM.
    w_tw   = (MAX_LOG2N-1)'(w_pos) << (4'(MAX_LOG2N - 1) - w_calc_s);
  end

  // Sequencer FSM with registered outputs; abort overrides every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_log2n       <= '0;
      r_inverse     <= 1'b0;
      r_s           <= '0;
      r_j           <= '0;
      r_drain       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_result_bank <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_addr_a   <= '0;
      r_rd_addr_b   <= '0;
      r_rd_bank     <= 1'b0;
      r_tw_addr     <= '0;
    end else if (i_abort) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_log2n   <= i_log2n;
            r_inverse <= i_inverse;
            if (w_start_ok) begin
              r_state     <= StIssue;
              r_busy      <= 1'b1;
              r_j         <= '0;
              r_s         <= '0;
              r_rd_en     <= 1'b1;
              r_rd_addr_a <= w_a;
              r_rd_addr_b <= w_b;
              r_rd_bank   <= w_calc_s[0];
              r_tw_addr   <= w_tw;
            end else begin
              r_state <= StErr;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (w_last_j) begin
            r_state <= StDrain;
            r_rd_en <= 1'b0;
            r_drain <= '0;
          end else begin
            r_j         <= w_calc_j;
            r_rd_addr_a <= w_a;
            r_rd_addr_b <= w_b;
            r_tw_addr   <= w_tw;
          end
        end
        StDrain: begin
          if (!w_drain_end) begin
            r_drain <= r_drain + DW'(1);
          end else if (w_last_s) begin
            r_state       <= StDone;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_result_bank <= r_log2n[0];
          end else begin
            // Last write of the stage lands this cycle; next stage may read it.
            r_state     <= StIssue;
            r_s         <= w_calc_s;
            r_j         <= '0;
            r_rd_en     <= 1'b1;
            r_rd_addr_a <= w_a;
            r_rd_addr_b <= w_b;
            r_rd_bank   <= w_calc_s[0];
            r_tw_addr   <= w_tw;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        StErr: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  fft_stage_sequencer_pipe_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (MAX_LOG2N)
  ) u_pipe_delay (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_flush  (i_abort),
    .i_valid  (r_rd_en),
    .i_addr_a (r_rd_addr_a),
    .i_addr_b (r_rd_addr_b),
    .i_bank   (~r_rd_bank),
    .o_valid  (o_wr_en),
    .o_addr_a (o_wr_addr_a),
    .o_addr_b (o_wr_addr_b),
    .o_bank   (o_wr_bank)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_rd_en       = r_rd_en;
  assign o_rd_addr_a   = r_rd_addr_a;
  assign o_rd_addr_b   = r_rd_addr_b;
  assign o_rd_bank     = r_rd_bank;
  assign o_tw_addr     = r_tw_addr;
  assign o_tw_conj     = r_inverse;
  assign o_scale_half  = r_inverse;
  assign o_result_bank = r_result_bank;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (MAX_LOG2N=10, PIPE_LAT=4).
module tb_fft_stage_sequencer;

  localparam int ML = 10;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    log2n = 4'd0;
  logic          inverse = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, err, rd_en, rd_bank, tw_conj, scale_half;
  logic          wr_en, wr_bank, result_bank;
  logic [ML-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [ML-2:0] tw_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer #(
    .MAX_LOG2N (ML),
    .PIPE_LAT  (PL)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_log2n       (log2n),
    .i_inverse     (inverse),
    .i_abort       (abort),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_rd_en       (rd_en),
    .o_rd_addr_a   (rd_addr_a),
    .o_rd_addr_b   (rd_addr_b),
    .o_rd_bank     (rd_bank),
    .o_tw_addr     (tw_addr),
    .o_tw_conj     (tw_conj),
    .o_scale_half  (scale_half),
    .o_wr_en       (wr_en),
    .o_wr_addr_a   (wr_addr_a),
    .o_wr_addr_b   (wr_addr_b),
    .o_wr_bank     (wr_bank),
    .o_result_bank (result_bank)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected read issue at cycle c of a run of size L: {en, bank, a, b, tw}.
  function automatic logic [30:0] model_rd(input int c, input int L);
    int n, p, k, s, j, half, pos, grp, a, b, tw;
    model_rd = '0;
    n = 1 << L;
    p = n / 2 + PL;
    if (c >= 1 && c <= L * p) begin
      k = c - 1;
      s = k / p;
      j = k % p;
      if (j < n / 2) begin
        half = 1 << s;
        pos  = j & (half - 1);
        grp  = j >> s;
        a    = (grp << (s + 1)) | pos;
        b    = a + half;
        tw   = pos << (ML - 1 - s);
        model_rd = {1'b1, s[0], a[9:0], b[9:0], tw[8:0]};
      end
    end
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, err, rd_en, rd_addr_a, rd_addr_b, rd_bank, tw_addr, tw_conj,
                scale_half, wr_en, wr_addr_a, wr_addr_b, wr_bank, result_bank});
  endfunction

  // One run from start; optional start poke mid-run and optional abort cycle.
  task automatic run_full(input int L, input bit inv, input int poke_c, input int abort_c);
    int n, p, last, nrd, nwr;
    logic [30:0] m, mw, obs_rd;
    logic [21:0] obs_wr, exp_wr;
    logic [3:0]  seen;
    n = 1 << L;
    p = n / 2 + PL;
    last = (abort_c > 0) ? abort_c : L * p + 1;
    nrd = 0;
    nwr = 0;
    tick();
    start = 1'b1;
    log2n = L[3:0];
    inverse = inv;
    for (int c = 1; c <= last; c++) begin
      tick();
      start = (c == poke_c) || (c == L * p + 1);
      if (start) begin
        log2n = 4'd5;
        inverse = ~inv;
      end
      m = model_rd(c, L);
      obs_rd = rd_en ? {1'b1, rd_bank, rd_addr_a, rd_addr_b, tw_addr} : '0;
      chk("rd", 64'(obs_rd), 64'(m));
      mw = model_rd(c - PL, L);
      exp_wr = mw[30] ? {1'b1, ~mw[29], mw[28:9]} : '0;
      obs_wr = wr_en ? {1'b1, wr_bank, wr_addr_a, wr_addr_b} : '0;
      chk("wr", 64'(obs_wr), 64'(exp_wr));
      chk("ctl", 64'({busy, done, err, tw_conj, scale_half}),
          64'({(c <= L * p), (c == L * p + 1), 1'b0, inv, inv}));
      if (c == L * p + 1) chk("result_bank", 64'(result_bank), 64'(L[0]));
      if (c == 1) chk("first_bfly", 64'({rd_en, rd_addr_a, rd_addr_b, tw_addr}),
                      64'({1'b1, 10'd0, 10'd1, 9'd0}));
      if (L == 3 && c == 12) chk("s1_j3", 64'({rd_en, rd_addr_a, rd_addr_b, tw_addr}),
                                 64'({1'b1, 10'd5, 10'd7, 9'd256}));
      if (L == 3 && c == 18) chk("s2_j1", 64'({rd_en, rd_addr_a, rd_addr_b, tw_addr}),
                                 64'({1'b1, 10'd1, 10'd5, 9'd128}));
      if (L == 1 && c == 5) chk("l1_wr", 64'({wr_en, wr_addr_a, wr_addr_b, wr_bank}),
                                64'({1'b1, 10'd0, 10'd1, 1'b1}));
      nrd += int'(rd_en);
      nwr += int'(wr_en);
    end
    if (abort_c > 0) begin
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_next", 64'({busy, done, rd_en, wr_en}), 64'(0));
      seen = '0;
      for (int i = 0; i < 20; i++) begin
        tick();
        seen |= {busy, done, rd_en, wr_en};
      end
      chk("abort_quiet", 64'(seen), 64'(0));
    end else begin
      tick();
      start = 1'b0;
      chk("idle_after", 64'({busy, done, err, rd_en, wr_en}), 64'(0));
      chk("n_rd", 64'(nrd), 64'(L * n / 2));
      chk("n_wr", 64'(nwr), 64'(L * n / 2));
    end
  endtask

  task automatic run_err(input int L);
    tick();
    start = 1'b1;
    log2n = L[3:0];
    inverse = 1'b0;
    tick();
    start = 1'b0;
    chk("err_c1", 64'({busy, done, err, rd_en, wr_en}), 64'(5'b01100));
    tick();
    chk("err_c2", 64'({busy, done, err, rd_en, wr_en}), 64'(0));
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    chk("reset", all_outs(), 64'(0));
    rst_n = 1'b1;

    // N=8 with a start poke while busy and another in the done cycle.
    run_full(3, 1'b0, 10, 0);

    // Full-size inverse transform.
    run_full(10, 1'b1, 0, 0);

    // Out-of-range sizes.
    run_err(0);
    run_err(11);

    // Abort during stage 1 of N=16.
    run_full(4, 1'b0, 0, 15);

    // Abort and start together in idle: abort wins.
    tick();
    start = 1'b1;
    abort = 1'b1;
    log2n = 4'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins", 64'({busy, done, err, rd_en}), 64'(0));
    run_full(4, 1'b0, 0, 0);

    // Reset mid-run clears outputs immediately.
    tick();
    start = 1'b1;
    log2n = 4'd3;
    inverse = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset", all_outs(), 64'(0));
    tick();
    rst_n = 1'b1;

    // Single-butterfly transform after the reset.
    run_full(1, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
